// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy obstacle field.
// Geometry defaults, LFSR seed/taps and score limit live here.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2
    } state_t;

    localparam int SCREEN_W    = 640;
    localparam int PIPE_W      = 60;
    localparam int GAP_H       = 120;
    localparam int SPACING     = 220;
    localparam int SCROLL_STEP = 2;
    localparam int BIRD_SIZE   = 20;
    localparam int FLOOR_Y     = 450;
    localparam int N_PIPES     = 3;

    localparam logic [8:0]  INIT_GAP  = 9'd180;
    localparam logic [8:0]  GAP_MIN   = 9'd60;
    localparam logic [9:0]  SCORE_MAX = 10'd999;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois right-shift form of taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pipe_field_lfsr16.sv
// Free-running 16-bit Galois LFSR, seeded on reset.
// Only the low byte is consumed downstream, so only it is exported.
module lfsr16
    import flappy_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] o_low
);

    logic [15:0] r_lfsr;

    // advance every clock; a nonzero seed keeps it out of the zero state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_low = r_lfsr[7:0];

endmodule

// File: rtl/pipe_field.sv
// Scrolling three-pipe obstacle field with collision and scoring.
// All evaluation uses the pre-tick registered pipe state.
module pipe_field
    import flappy_pkg::*;
#(
    parameter int P_SCROLL_STEP = SCROLL_STEP,
    parameter int P_PIPE_W      = PIPE_W,
    parameter int P_GAP_H       = GAP_H,
    parameter int P_SPACING     = SPACING,
    parameter int P_SCREEN_W    = SCREEN_W,
    parameter int P_BIRD_SIZE   = BIRD_SIZE,
    parameter int P_FLOOR_Y     = FLOOR_Y
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        pause,
    input  logic        restart,
    input  logic        game_state,
    input  logic [9:0]  bird_x,
    input  logic [8:0]  bird_y,
    output logic [10:0] pipe0_x,
    output logic [10:0] pipe1_x,
    output logic [10:0] pipe2_x,
    output logic [8:0]  pipe0_gap,
    output logic [8:0]  pipe1_gap,
    output logic [8:0]  pipe2_gap,
    output logic        collision,
    output logic        score_pulse,
    output logic [9:0]  current_score,
    output logic [9:0]  highest_score
);

    localparam logic [10:0] L_STEP  = 11'(P_SCROLL_STEP);
    // respawn offset: x - step + 3*spacing, folded so nothing goes negative
    localparam logic [10:0] L_WRAP  = 11'(3 * P_SPACING - P_SCROLL_STEP);
    localparam logic [11:0] L_HREACH = 12'(P_BIRD_SIZE + P_PIPE_W);
    localparam logic [11:0] L_BSIZE = 12'(P_BIRD_SIZE);
    localparam logic [11:0] L_GAPH  = 12'(P_GAP_H);
    localparam logic [11:0] L_FLOOR = 12'(P_FLOOR_Y);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [10:0] r_x   [N_PIPES];
    logic [8:0]  r_gap [N_PIPES];
    logic [10:0] w_x_init [N_PIPES];
    logic [10:0] w_x_new  [N_PIPES];
    logic [8:0]  w_gap_new [N_PIPES];

    logic [N_PIPES-1:0] w_hit;
    logic [N_PIPES-1:0] w_pass;

    logic [9:0]  r_cur;
    logic [9:0]  r_high;
    logic        r_pulse;
    logic        r_coll;

    logic [7:0]  w_rand;
    logic [11:0] w_bx;
    logic [11:0] w_by;
    logic        w_step;
    logic        w_floor;
    logic        w_crash;
    logic        w_scroll;
    logic        w_reload;
    logic        w_any_pass;
    logic [9:0]  w_cur_inc;
    logic [9:0]  w_high_new;

    lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .o_low (w_rand)
    );

    assign w_bx = {2'b00, bird_x};
    assign w_by = {3'b000, bird_y};

    assign w_step   = (r_state == ST_RUN) && tick && !pause;
    assign w_floor  = (w_by >= L_FLOOR);
    assign w_crash  = w_step && (w_floor || (|w_hit));
    assign w_scroll = w_step && !w_crash;
    assign w_reload = (r_state == ST_CRASH) && restart;

    for (genvar g = 0; g < N_PIPES; g++) begin : g_pipe
        logic [11:0] w_px;
        logic [11:0] w_pg;
        logic        w_hov;
        logic        w_vfail;
        logic        w_respawn;

        assign w_x_init[g] = 11'(P_SCREEN_W + P_PIPE_W + g * P_SPACING);

        assign w_px = {1'b0, r_x[g]};
        assign w_pg = {3'b000, r_gap[g]};

        // bird_x+size > x-width, rearranged to stay non-negative
        assign w_hov   = (w_bx < w_px) && ((w_bx + L_HREACH) > w_px);
        assign w_vfail = (w_by < w_pg) || ((w_by + L_BSIZE) > (w_pg + L_GAPH));
        assign w_hit[g] = w_hov && w_vfail;

        assign w_respawn  = (r_x[g] <= L_STEP);
        assign w_x_new[g] = w_respawn ? (r_x[g] + L_WRAP)
                                      : (r_x[g] - L_STEP);
        assign w_gap_new[g] = w_respawn ? (GAP_MIN + {1'b0, w_rand})
                                        : r_gap[g];

        assign w_pass[g] = (r_x[g] > {1'b0, bird_x})
                        && (w_x_new[g] <= {1'b0, bird_x});
    end

    assign w_any_pass = |w_pass;
    assign w_cur_inc  = (r_cur >= SCORE_MAX) ? SCORE_MAX : (r_cur + 10'd1);
    assign w_high_new = (w_cur_inc > r_high) ? w_cur_inc : r_high;

    // game state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state: start on game_state, crash on hit, leave crash on restart
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (game_state) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_crash) begin
                    w_state_nxt = ST_CRASH;
                end
            end
            ST_CRASH: begin
                if (restart) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // pipe positions and gaps: reload on restart, scroll on a clean tick
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PIPES; i++) begin
                r_x[i]   <= w_x_init[i];
                r_gap[i] <= INIT_GAP;
            end
        end else if (w_reload) begin
            for (int i = 0; i < N_PIPES; i++) begin
                r_x[i]   <= w_x_init[i];
                r_gap[i] <= INIT_GAP;
            end
        end else if (w_scroll) begin
            for (int i = 0; i < N_PIPES; i++) begin
                r_x[i]   <= w_x_new[i];
                r_gap[i] <= w_gap_new[i];
            end
        end
    end

    // scoring: one pulse per passing tick, saturating current, running max
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cur   <= '0;
            r_high  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_reload) begin
                r_cur <= '0;
            end else if (w_scroll && w_any_pass) begin
                r_pulse <= 1'b1;
                r_cur   <= w_cur_inc;
                r_high  <= w_high_new;
            end
        end
    end

    // collision flag tracks the crash state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_coll <= 1'b0;
        end else if (w_crash) begin
            r_coll <= 1'b1;
        end else if (w_reload) begin
            r_coll <= 1'b0;
        end
    end

    assign pipe0_x       = r_x[0];
    assign pipe1_x       = r_x[1];
    assign pipe2_x       = r_x[2];
    assign pipe0_gap     = r_gap[0];
    assign pipe1_gap     = r_gap[1];
    assign pipe2_gap     = r_gap[2];
    assign collision     = r_coll;
    assign score_pulse   = r_pulse;
    assign current_score = r_cur;
    assign highest_score = r_high;

endmodule

// File: tb/tb_pipe_field.sv
// Directed bench for pipe_field with a reference model and scoreboard.
// Expected snapshots are queued per clock and compared after the edge.
module tb_pipe_field;

    logic        clock;
    logic        reset;
    logic        tick;
    logic        pause;
    logic        restart;
    logic        game_state;
    logic [9:0]  bird_x;
    logic [8:0]  bird_y;
    logic [10:0] pipe0_x, pipe1_x, pipe2_x;
    logic [8:0]  pipe0_gap, pipe1_gap, pipe2_gap;
    logic        collision;
    logic        score_pulse;
    logic [9:0]  current_score;
    logic [9:0]  highest_score;

    pipe_field dut (
        .clock         (clock),
        .reset         (reset),
        .tick          (tick),
        .pause         (pause),
        .restart       (restart),
        .game_state    (game_state),
        .bird_x        (bird_x),
        .bird_y        (bird_y),
        .pipe0_x       (pipe0_x),
        .pipe1_x       (pipe1_x),
        .pipe2_x       (pipe2_x),
        .pipe0_gap     (pipe0_gap),
        .pipe1_gap     (pipe1_gap),
        .pipe2_gap     (pipe2_gap),
        .collision     (collision),
        .score_pulse   (score_pulse),
        .current_score (current_score),
        .highest_score (highest_score)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int x0, x1, x2;
        int g0, g1, g2;
        int cur, high, coll, pulse;
    } snap_t;

    snap_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_st;
    int m_x [3];
    int m_g [3];
    int m_cur, m_high, m_coll, m_pulse;
    logic [15:0] m_lfsr;

    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else if (m_lfsr[0]) m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
        else m_lfsr <= m_lfsr >> 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic m_home();
        for (int i = 0; i < 3; i++) begin
            m_x[i] = 700 + i * 220;
            m_g[i] = 180;
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_cur = 0; m_high = 0; m_coll = 0; m_pulse = 0;
        m_home();
    endtask

    task automatic model_cycle();
        int  bx, by, nx;
        bit  hit, pass;
        bx = int'(bird_x);
        by = int'(bird_y);
        m_pulse = 0;
        case (m_st)
            0: if (game_state) m_st = 1;
            1: if (tick && !pause) begin
                hit = (by >= 450);
                for (int i = 0; i < 3; i++)
                    if (bx < m_x[i] && bx + 20 > m_x[i] - 60 &&
                        (by < m_g[i] || by + 20 > m_g[i] + 120))
                        hit = 1;
                if (hit) begin
                    m_st = 2;
                    m_coll = 1;
                end else begin
                    pass = 0;
                    for (int i = 0; i < 3; i++) begin
                        nx = m_x[i] - 2;
                        if (m_x[i] <= 2) begin
                            nx = nx + 660;
                            m_g[i] = 60 + int'(m_lfsr[7:0]);
                        end
                        if (m_x[i] > bx && nx <= bx) pass = 1;
                        m_x[i] = nx;
                    end
                    if (pass) begin
                        m_pulse = 1;
                        if (m_cur < 999) m_cur++;
                        if (m_cur > m_high) m_high = m_cur;
                    end
                end
            end
            default: if (restart) begin
                m_st = 0; m_coll = 0; m_cur = 0;
                m_home();
            end
        endcase
    endtask

    task automatic compare_all(input snap_t e);
        check("pipe0_x", int'(pipe0_x), e.x0);
        check("pipe1_x", int'(pipe1_x), e.x1);
        check("pipe2_x", int'(pipe2_x), e.x2);
        check("pipe0_gap", int'(pipe0_gap), e.g0);
        check("pipe1_gap", int'(pipe1_gap), e.g1);
        check("pipe2_gap", int'(pipe2_gap), e.g2);
        check("current_score", int'(current_score), e.cur);
        check("highest_score", int'(highest_score), e.high);
        check("collision", int'(collision), e.coll);
        check("score_pulse", int'(score_pulse), e.pulse);
    endtask

    task automatic step();
        snap_t e;
        model_cycle();
        e.x0 = m_x[0]; e.x1 = m_x[1]; e.x2 = m_x[2];
        e.g0 = m_g[0]; e.g1 = m_g[1]; e.g2 = m_g[2];
        e.cur = m_cur; e.high = m_high;
        e.coll = m_coll; e.pulse = m_pulse;
        q.push_back(e);
        @(posedge clock);
        #1;
        compare_all(q.pop_front());
    endtask

    task automatic do_tick(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic check_home(input string tag);
        check({tag, "_x0"}, int'(pipe0_x), 700);
        check({tag, "_x1"}, int'(pipe1_x), 920);
        check({tag, "_x2"}, int'(pipe2_x), 1140);
        check({tag, "_g0"}, int'(pipe0_gap), 180);
        check({tag, "_g2"}, int'(pipe2_gap), 180);
    endtask

    int saved_x;
    int guard;

    initial begin
        reset = 1'b0; tick = 1'b0; pause = 1'b0; restart = 1'b0;
        game_state = 1'b0; bird_x = 10'd140; bird_y = 9'd200;
        m_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        // reset state
        check_home("reset");
        check("reset_cur", int'(current_score), 0);
        check("reset_high", int'(highest_score), 0);
        check("reset_coll", int'(collision), 0);
        check("reset_pulse", int'(score_pulse), 0);

        // idle hold
        do_tick(100);
        check_home("idle");

        // run and pass pipe0
        game_state = 1'b1;
        step();
        do_tick(279);
        check("pre_pass_x0", int'(pipe0_x), 142);
        check("pre_pass_cur", int'(current_score), 0);
        tick = 1'b1;
        step();
        check("pass_x0", int'(pipe0_x), 140);
        check("pass_pulse", int'(score_pulse), 1);
        check("pass_cur", int'(current_score), 1);
        check("pass_high", int'(highest_score), 1);
        check("pass_coll", int'(collision), 0);
        tick = 1'b0;
        step();
        check("pulse_drop", int'(score_pulse), 0);

        // run until pipe0 reaches 2, then recycle
        guard = 0;
        while (pipe0_x != 11'd2 && guard < 200) begin
            do_tick(1);
            guard++;
        end
        check("reach_x2", int'(pipe0_x), 2);
        do_tick(1);
        check("recycle_x0", int'(pipe0_x), 660);

        // pause freezes motion
        saved_x = int'(pipe1_x);
        pause = 1'b1;
        do_tick(50);
        pause = 1'b0;
        check("pause_x1", int'(pipe1_x), saved_x);

        // floor crash, ignored tick in crash, restart
        saved_x = int'(pipe0_x);
        bird_y = 9'd450;
        do_tick(1);
        check("floor_coll", int'(collision), 1);
        check("floor_noscroll", int'(pipe0_x), saved_x);
        bird_y = 9'd200;
        do_tick(2);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_coll", int'(collision), 0);
        check("restart_cur", int'(current_score), 0);
        check("restart_high", int'(highest_score), 1);
        check_home("restart");
        step();

        // async reset in the middle of a run
        do_tick(10);
        #3;
        reset = 1'b0;
        m_reset();
        #1;
        check_home("areset");
        check("areset_high", int'(highest_score), 0);
        check("areset_cur", int'(current_score), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // pipe collision with a low bird
        bird_y = 9'd100;
        step();
        do_tick(241);
        check("pre_hit_x0", int'(pipe0_x), 218);
        check("pre_hit_coll", int'(collision), 0);
        do_tick(1);
        check("hit_x0", int'(pipe0_x), 218);
        check("hit_coll", int'(collision), 1);
        do_tick(1);
        check("hit_freeze", int'(pipe0_x), 218);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_field.md
# pipe_field

Scrolling obstacle stage that sits directly downstream of the bird-physics block. It consumes `game_state`, `bird_x` and `bird_y`, and advances three pipes once per frame tick. It draws a fresh gap height from an LFSR whenever a pipe is recycled, detects bird/pipe and bird/floor collisions, and owns the current and highest score. Its outputs drive the VGA renderer and the score display.

## Interface
- `SCROLL_STEP`, 2, pixels moved per tick
- `PIPE_W`, 60, pipe width in pixels
- `GAP_H`, 120, vertical gap height
- `SPACING`, 220, right-edge distance between consecutive pipes
- `SCREEN_W`, 640, visible width
- `BIRD_SIZE`, 20, bird bounding-box edge
- `FLOOR_Y`, 450, crash when `bird_y >= FLOOR_Y`
- `clock` in 1: the single clock
- `reset` in 1: asynchronous, active-low
- `tick` in 1: one-cycle frame strobe
- `pause` in 1: when high, ticks are ignored
- `restart` in 1: one-cycle pulse that leaves CRASH
- `game_state` in 1: high while the bird is flying
- `bird_x` in 10: bird box left edge
- `bird_y` in 9: bird box top edge
- `pipe0_x`, `pipe1_x`, `pipe2_x` out 11: pipe right edges; visible span is [x-PIPE_W, x)
- `pipe0_gap`, `pipe1_gap`, `pipe2_gap` out 9: gap top; gap spans [gap, gap+GAP_H)
- `collision` out 1: high while in CRASH
- `score_pulse` out 1: one-cycle strobe per pipe passed
- `current_score` out 10: current score
- `highest_score` out 10: highest score

## Operation
- **States:** IDLE, RUN, CRASH. IDLE→RUN when `game_state` is high. CRASH→IDLE on `restart`. All other inputs are ignored in CRASH.
- **Reset values:**
  - State is IDLE.
  - `pipeN_x` = SCREEN_W+PIPE_W+N·SPACING, i.e. 700, 920, 1140.
  - All gaps are 180.
  - Both scores are 0. `collision` and `score_pulse` are 0.
  - LFSR is 16'hACE1.
- **IDLE:** pipes are held at their reset positions and gaps. On entering IDLE from CRASH, positions and gaps reload to reset values, `current_score` clears, and `highest_score` is kept.
- **RUN, on `tick` && !`pause`, evaluated in order on the pre-tick registered pipe values:**
  1. **Collision check.**
     - Floor hit if `bird_y >= FLOOR_Y`.
     - Pipe hit if, for any pipe, the horizontal spans overlap and the vertical check fails.
     - Horizontal overlap: `bird_x < x` and `bird_x+BIRD_SIZE > x-PIPE_W`.
     - Vertical fail: `bird_y < gap` or `bird_y+BIRD_SIZE > gap+GAP_H`.
     - Any hit → CRASH. On that tick nothing scrolls and no score is given.
  2. **Scroll.**
     - If `x <= SCROLL_STEP`, then `x_new = x - SCROLL_STEP + 3·SPACING`, and the gap takes `60 + lfsr[7:0]` (range 60..315).
     - Otherwise `x_new = x - SCROLL_STEP`.
  3. **Score.**
     - A pipe with `x > bird_x` and `x_new <= bird_x` pulses `score_pulse`.
     - `current_score` increments and saturates at 999.
     - `highest_score` is set to max(high, new current) in the same cycle.
- **Arithmetic:** done in 11 bits, plus 1 guard bit for the bird-box sums. No negative intermediates are ever formed.
- **LFSR:** Galois, taps 16,14,13,11. It advances every clock in every state, including during pause. It is never zero.
- **Simultaneous respawns:** two pipes can never respawn on the same tick (spacing > step). If the invariant were violated, each respawning pipe uses the same lfsr sample.
- **Pause:** `tick` is ignored entirely while `pause` is high; all state freezes except the LFSR.
- **Reset mid-game:** everything returns immediately to reset values, including `highest_score`.

## Timing
- All outputs are registered.
- Pipe positions, gaps, scores, `score_pulse` and `collision` update on the clock edge that samples `tick`; the values are visible the following cycle. Latency is 1 cycle.
- `score_pulse` is high for exactly one cycle per pipe passed.
- `collision` rises on the crash tick and falls the cycle after `restart` is sampled.
- `game_state` is level-sampled on every clock in IDLE. No tick is required for IDLE→RUN.
- `restart` outside CRASH has no effect.

## Structure
- A shared package `flappy_pkg` holds:
  - the state enum (IDLE/RUN/CRASH);
  - constants for the screen, bird size, floor and initial gap;
  - the LFSR seed and taps;
  - the score saturation limit (999).
- One sub-module is natural: `lfsr16`, a free-running 16-bit LFSR with seed load on reset.
- The per-pipe update logic is replicated three times with a generate loop; it is not split into separate modules.

## Test plan
- **Reset and idle:** apply reset and hold `game_state`=0 for 100 ticks → pipes stay at 700/920/1140, gaps stay 180, scores stay 0.
- **Score on pass:** `bird_x`=140, `bird_y`=200, `game_state`=1 → 280th tick gives `pipe0_x`=140, one `score_pulse`, `current_score`=1, `highest_score`=1, and no collision.
- **Pipe collision:** `bird_x`=140, `bird_y`=100 → CRASH on the 242nd tick (pre-tick x=218). `pipe0_x` freezes at 218 and `collision`=1.
- **Floor crash and restart:** `bird_y`=450 on the first RUN tick → CRASH with no scroll. `restart` → IDLE, `current_score` clears, `highest_score` is kept.
- **Recycle:** run with `bird_y`=200 until `pipe0_x`=2 → next tick gives `pipe0_x`=660, and `pipe0_gap` equals 60 + lfsr[7:0] (checked against a reference LFSR model).
- **Pause and async reset:** hold `pause` high for 50 ticks → no movement. Assert `reset` low mid-RUN between clock edges → outputs return to reset values before the next edge.
